jtag_shift_engine: RTL and testbench

Sequencer directly upstream of the adapter's JTAG pin-buffer stage.
- Accepts byte-wide shift commands over a valid/ready interface.
- Generates the TCK/TDI/TMS waveforms that feed the buffer stage's FT_TCK/FT_TDI/FT_TMS inputs.
- Captures TDO and returns it as a byte-wide response.
- Supports a fixed programmable TCK divider and adaptive clocking against the returned RTCK.

---
 rtl/jtag_pkg.sv | 16 +
 rtl/jtag_shift_engine_sync2.sv | 20 ++
 rtl/jtag_shift_engine.sv | 208 ++++++++++++++++++++
 tb/tb_jtag_shift_engine.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
// Shared types and constants for the JTAG shift engine.
package jtag_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        WAIT_RH,
        WAIT_RL,
        RESP
    } state_t;

    localparam int MIN_DIV    = 2;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/jtag_shift_engine_sync2.sv
// Two-flop synchronizer for the asynchronous TDO/RTCK pins.
module sync2
    import jtag_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_DEPTH-1:0] ff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ff <= '0;
        else     ff <= {ff[SYNC_DEPTH-2:0], d};
    end

    assign q = ff[SYNC_DEPTH-1];

endmodule

// File: rtl/jtag_shift_engine.sv
// Byte-wide JTAG shift sequencer: drives TCK/TDI/TMS, captures TDO,
// with a fixed half-period divider or adaptive clocking against RTCK.
module jtag_shift_engine
    import jtag_pkg::*;
#(
    parameter int DIV_W  = 8,
    parameter int TO_CYC = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_data,
    input  logic [2:0]       cmd_len,
    input  logic             cmd_tms,
    input  logic             cmd_tms_last,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_err,
    input  logic [DIV_W-1:0] div,
    input  logic             adaptive,
    output logic             tck,
    output logic             tdi,
    output logic             tms,
    input  logic             tdo,
    input  logic             rtck,
    output logic             busy
);

    localparam int TO_W = $clog2(TO_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(MIN_DIV);

    state_t state, state_n;

    logic [7:0]       data_q, data_n;
    logic [2:0]       len_q, len_n;
    logic [2:0]       idx_q, idx_n;
    logic             tmsb_q, tmsb_n;
    logic             tmsl_q, tmsl_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic [DIV_W-1:0] cnt_q, cnt_n;
    logic             adp_q, adp_n;
    logic [TO_W-1:0]  to_q, to_n;
    logic [7:0]       cap_q, cap_n;
    logic             err_q, err_n;
    logic             vld_q, vld_n;
    logic             tck_q, tck_n;
    logic             tdi_q, tdi_n;
    logic             tms_q, tms_n;
    logic             tdo_s, rtck_s;

    sync2 u_sync_tdo  (.clk(clk), .rst(rst), .d(tdo),  .q(tdo_s));
    sync2 u_sync_rtck (.clk(clk), .rst(rst), .d(rtck), .q(rtck_s));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            data_q <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            tmsb_q <= 1'b1;
            tmsl_q <= 1'b1;
            div_q  <= DIV_MIN;
            cnt_q  <= '0;
            adp_q  <= 1'b0;
            to_q   <= '0;
            cap_q  <= '0;
            err_q  <= 1'b0;
            vld_q  <= 1'b0;
            tck_q  <= 1'b0;
            tdi_q  <= 1'b0;
            tms_q  <= 1'b1;
        end else begin
            state  <= state_n;
            data_q <= data_n;
            len_q  <= len_n;
            idx_q  <= idx_n;
            tmsb_q <= tmsb_n;
            tmsl_q <= tmsl_n;
            div_q  <= div_n;
            cnt_q  <= cnt_n;
            adp_q  <= adp_n;
            to_q   <= to_n;
            cap_q  <= cap_n;
            err_q  <= err_n;
            vld_q  <= vld_n;
            tck_q  <= tck_n;
            tdi_q  <= tdi_n;
            tms_q  <= tms_n;
        end
    end

    always_comb begin
        state_n = state;
        data_n  = data_q;
        len_n   = len_q;
        idx_n   = idx_q;
        tmsb_n  = tmsb_q;
        tmsl_n  = tmsl_q;
        div_n   = div_q;
        cnt_n   = cnt_q;
        adp_n   = adp_q;
        to_n    = to_q;
        cap_n   = cap_q;
        err_n   = err_q;
        vld_n   = vld_q;
        tdi_n   = tdi_q;
        tms_n   = tms_q;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    data_n  = cmd_data;
                    len_n   = cmd_len;
                    tmsb_n  = cmd_tms;
                    tmsl_n  = cmd_tms_last;
                    div_n   = (div < DIV_MIN) ? DIV_MIN : div;
                    adp_n   = adaptive;
                    idx_n   = '0;
                    cnt_n   = '0;
                    cap_n   = '0;
                    err_n   = 1'b0;
                    state_n = LOW;
                end
            end
            LOW: begin
                if (cnt_q == div_q) begin
                    cnt_n   = '0;
                    to_n    = '0;
                    state_n = adp_q ? WAIT_RH : HIGH;
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            WAIT_RH: begin
                if (rtck_s) begin
                    cnt_n   = '0;
                    state_n = HIGH;
                end else if (to_q == TO_LAST) begin
                    err_n   = 1'b1;
                    state_n = RESP;
                end else begin
                    to_n = to_q + 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == div_q) begin
                    cap_n[idx_q] = tdo_s;
                    cnt_n        = '0;
                    to_n         = '0;
                    if (adp_q) begin
                        state_n = WAIT_RL;
                    end else if (idx_q == len_q) begin
                        state_n = RESP;
                    end else begin
                        idx_n   = idx_q + 3'd1;
                        state_n = LOW;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end
            WAIT_RL: begin
                if (!rtck_s) begin
                    cnt_n = '0;
                    if (idx_q == len_q) begin
                        state_n = RESP;
                    end else begin
                        idx_n   = idx_q + 3'd1;
                        state_n = LOW;
                    end
                end else if (to_q == TO_LAST) begin
                    err_n   = 1'b1;
                    state_n = RESP;
                end else begin
                    to_n = to_q + 1'b1;
                end
            end
            RESP: begin
                vld_n = 1'b1;
                if (vld_q && rsp_ready) begin
                    vld_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Pins are registered from the next state so they switch with it
        tck_n = (state_n == HIGH) || (state_n == WAIT_RH);
        if (state_n == LOW) begin
            tdi_n = data_n[idx_n];
            tms_n = (idx_n == len_n) ? tmsl_n : tmsb_n;
        end
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rsp_valid = vld_q;
    assign rsp_data  = cap_q;
    assign rsp_err   = err_q;
    assign tck       = tck_q;
    assign tdi       = tdi_q;
    assign tms       = tms_q;

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed self-checking bench for jtag_shift_engine.
module tb_jtag_shift_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_data = '0;
    logic [2:0] cmd_len = '0;
    logic       cmd_tms = 1'b0;
    logic       cmd_tms_last = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [7:0] div = '0;
    logic       adaptive = 1'b0;
    logic       tck, tdi, tms, tdo, rtck, busy;

    logic [7:0] tdo_sr = '0;
    logic       tdo_fill = 1'b0;
    logic       adp_echo = 1'b0;
    logic [9:0] hist = '0;
    int         cyc = 0;

    int n_chk = 0;
    int n_fail = 0;

    int acc_cyc, rsp_cyc, nrise, nfall, run;
    int lmin, lmax, hmin, hmax, adp_min;
    int first_rise, err_cyc, rtck_rise;
    logic prev, prev_rtck;
    logic [7:0] tdi_bits, tms_bits;

    assign tdo  = tdo_sr[0];
    assign rtck = adp_echo & hist[9];

    jtag_shift_engine dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_len(cmd_len),
        .cmd_tms(cmd_tms), .cmd_tms_last(cmd_tms_last),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .div(div), .adaptive(adaptive),
        .tck(tck), .tdi(tdi), .tms(tms),
        .tdo(tdo), .rtck(rtck), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        hist <= {hist[8:0], tck};
    end

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] d, input logic [2:0] l,
                            input logic t, input logic tl,
                            input logic ad);
        int n;
        cmd_data = d;
        cmd_len = l;
        cmd_tms = t;
        cmd_tms_last = tl;
        adaptive = ad;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("acc_wait", n < 200, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        int n;
        nrise = 0; nfall = 0; run = 1;
        lmin = 9999; lmax = 0; hmin = 9999; hmax = 0;
        adp_min = 9999;
        first_rise = -1; err_cyc = -1; rtck_rise = -1;
        prev = tck; prev_rtck = rtck;
        tdi_bits = '0; tms_bits = '0;
        n = 0;
        while (!rsp_valid && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (tck != prev) begin
                if (prev) begin
                    if (run < hmin) hmin = run;
                    if (run > hmax) hmax = run;
                    nfall++;
                    tdo_sr = {tdo_fill, tdo_sr[7:1]};
                    if (rtck_rise >= 0 && cyc - rtck_rise < adp_min)
                        adp_min = cyc - rtck_rise;
                end else begin
                    if (run < lmin) lmin = run;
                    if (run > lmax) lmax = run;
                    if (nrise < 8) begin
                        tdi_bits[nrise] = tdi;
                        tms_bits[nrise] = tms;
                    end
                    if (first_rise < 0) first_rise = cyc;
                    nrise++;
                end
                prev = tck;
                run = 1;
            end else begin
                run++;
            end
            if (rtck && !prev_rtck) rtck_rise = cyc;
            prev_rtck = rtck;
            if (rsp_err && err_cyc < 0) err_cyc = cyc;
        end
        check("rsp_wait", n < 5000, 1);
        rsp_cyc = cyc;
    endtask

    task automatic retire();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nf, n, bad;
        logic pv;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("rst_tck", tck, 0);
        check("rst_tdi", tdi, 0);
        check("rst_tms", tms, 1);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);

        // Reset three bits into a shift
        send_cmd(8'hFF, 3'd7, 1'b0, 1'b0, 1'b0);
        nf = 0; n = 0; pv = tck;
        while (nf < 3 && n < 500) begin
            @(posedge clk); #1;
            n++;
            if (pv && !tck) nf++;
            pv = tck;
        end
        check("mid_tdi", tdi, 1);
        check("mid_tms", tms, 0);
        #3 rst = 1'b1;
        #1;
        check("arst_tck", tck, 0);
        check("arst_tms", tms, 1);
        check("arst_tdi", tdi, 0);
        check("arst_busy", busy, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        @(posedge clk); #1 rst = 1'b0;
        bad = 0;
        repeat (60) begin
            @(posedge clk); #1;
            if (rsp_valid) bad++;
        end
        check("arst_no_rsp", bad, 0);

        // 8-bit shift, div=0 -> 3-cycle phases
        tdo_sr = 8'h3C; tdo_fill = 1'b0; div = 8'd0;
        send_cmd(8'hA5, 3'd7, 1'b0, 1'b1, 1'b0);
        wait_rsp();
        check("a5_latency", rsp_cyc - acc_cyc, 49);
        check("a5_rsp_data", rsp_data, 8'h3C);
        check("a5_rsp_err", rsp_err, 0);
        check("a5_tdi_seq", tdi_bits, 8'hA5);
        check("a5_tms_seq", tms_bits, 8'h80);
        check("a5_nbits", nrise, 8);
        check("a5_low_min", lmin, 3);
        check("a5_low_max", lmax, 3);
        check("a5_high_min", hmin, 3);
        check("a5_high_max", hmax, 3);
        check("a5_cmd_ready", cmd_ready, 0);
        retire();
        check("a5_retired", rsp_valid, 0);

        // 3-bit shift, unused capture bits stay zero
        tdo_sr = 8'hFF; tdo_fill = 1'b1;
        send_cmd(8'hFF, 3'd2, 1'b0, 1'b0, 1'b0);
        wait_rsp();
        check("l3_latency", rsp_cyc - acc_cyc, 19);
        check("l3_rsp_data", rsp_data, 8'h07);
        check("l3_nbits", nrise, 3);
        check("l3_tdi_seq", tdi_bits, 8'h07);

        // Back-pressure with a second command pending
        cmd_data = 8'h01; cmd_len = 3'd0;
        cmd_tms = 1'b0; cmd_tms_last = 1'b1;
        adaptive = 1'b0;
        cmd_valid = 1'b1;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (cmd_ready !== 1'b0 || rsp_data !== 8'h07 || !rsp_valid)
                bad++;
        end
        check("bp_hold", bad, 0);
        tdo_sr = 8'h01; tdo_fill = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("bp_retired", rsp_valid, 0);
        check("bp_ready_next", cmd_ready, 1);
        @(posedge clk); #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
        check("bp_accepted", busy, 1);
        wait_rsp();
        check("bp_latency", rsp_cyc - acc_cyc, 7);
        check("bp_rsp_data", rsp_data, 8'h01);
        check("bp_tms_last", tms_bits, 8'h01);
        retire();

        // Adaptive clocking, RTCK echoes TCK 10 cycles late
        adp_echo = 1'b1;
        tdo_sr = 8'h3C; tdo_fill = 1'b0;
        send_cmd(8'hA5, 3'd7, 1'b0, 1'b1, 1'b1);
        wait_rsp();
        check("adp_rsp_err", rsp_err, 0);
        check("adp_rsp_data", rsp_data, 8'h3C);
        check("adp_tdi_seq", tdi_bits, 8'hA5);
        check("adp_high_after_rtck", adp_min >= 3, 1);
        retire();

        // Adaptive clocking, RTCK stuck low
        adp_echo = 1'b0;
        tdo_sr = 8'hFF; tdo_fill = 1'b1;
        send_cmd(8'h0F, 3'd7, 1'b0, 1'b1, 1'b1);
        wait_rsp();
        check("to_rsp_err", rsp_err, 1);
        check("to_delay", err_cyc - first_rise, 1023);
        check("to_tck", tck, 0);
        check("to_rsp_data", rsp_data, 8'h00);
        retire();

        tdo_sr = 8'hC3; tdo_fill = 1'b0;
        send_cmd(8'h5A, 3'd7, 1'b0, 1'b1, 1'b0);
        check("to_err_cleared", rsp_err, 0);
        wait_rsp();
        check("post_to_err", rsp_err, 0);
        check("post_to_data", rsp_data, 8'hC3);
        check("post_to_tdi", tdi_bits, 8'h5A);
        retire();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
